// File: rtl/gbus_ahb_master_pkg.sv
// Shared AHB-Lite encodings and the state type used by the gbus-to-AHB bridge.
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      SZ_BYTE = 3'd0,
      SZ_HALF = 3'd1,
      SZ_WORD = 3'd2
   } hsize_t;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_ERR2,
      S_LOCALERR
   } gbm_state_t;

endpackage

// File: rtl/gbus_ahb_master_if.sv
// AHB-Lite master/slave signal bundle.
interface ahb_if;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;

   modport ahb_m (
      output HTRANS, HWRITE, HADDR, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HREADY, HRESP, HRDATA
   );

   modport ahb_s (
      input  HTRANS, HWRITE, HADDR, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HREADY, HRESP, HRDATA
   );
endinterface

// File: rtl/gbus_ahb_size_decode.sv
// Maps a byte-lane mask to AHB transfer size and the low address bits.
// Illegal masks report bad_be and decode as an aligned word access.
module gbus_ahb_size_decode
   import ahb_pkg::*;
(
   input  logic [3:0] byte_en,
   output hsize_t     hsize,
   output logic [1:0] addr_lo,
   output logic       bad_be
);

   always_comb begin
      hsize   = SZ_WORD;
      addr_lo = 2'b00;
      bad_be  = 1'b0;
      case (byte_en)
         4'b1111: begin hsize = SZ_WORD; addr_lo = 2'b00; end
         4'b0011: begin hsize = SZ_HALF; addr_lo = 2'b00; end
         4'b1100: begin hsize = SZ_HALF; addr_lo = 2'b10; end
         4'b0001: begin hsize = SZ_BYTE; addr_lo = 2'b00; end
         4'b0010: begin hsize = SZ_BYTE; addr_lo = 2'b01; end
         4'b0100: begin hsize = SZ_BYTE; addr_lo = 2'b10; end
         4'b1000: begin hsize = SZ_BYTE; addr_lo = 2'b11; end
         default: bad_be = 1'b1;
      endcase
   end

endmodule

// File: rtl/gbus_ahb_master.sv
// Bridges the core's generic memory request bus to single AHB-Lite transfers,
// one outstanding transfer at a time.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | no transfer in flight; address phase driven when requested
//   S_DATA     | data phase of the issued transfer, waiting on HREADY
//   S_ERR2     | first ERROR cycle seen; finishing the two-cycle response
//   S_LOCALERR | illegal byte_en rejected without touching the bus
module gbus_ahb_master
   import ahb_pkg::*;
#(
   parameter logic [3:0] HPROT_VAL     = 4'b0011,
   parameter bit         ERR_ON_BAD_BE = 1'b1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        ren,
   input  logic        wen,
   input  logic [3:0]  byte_en,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        error,
   ahb_if.ahb_m        ahb
);

   gbm_state_t  state, state_nxt;
   logic [31:0] hwdata_q, rdata_q;
   hsize_t      dec_size;
   logic [1:0]  dec_lo;
   logic        dec_bad;
   logic        req, local_err, resp_err;
   logic        capture, rdata_load, rdata_clr;

   gbus_ahb_size_decode u_size_decode (
      .byte_en (byte_en),
      .hsize   (dec_size),
      .addr_lo (dec_lo),
      .bad_be  (dec_bad)
   );

   // Gating with nRST keeps the combinational address phase quiet while in reset.
   assign req       = (ren | wen) & nRST;
   assign local_err = dec_bad & ERR_ON_BAD_BE;
   assign resp_err  = |(ahb.HRESP & HRESP_ERROR);

   assign ahb.HBURST    = HBURST_SINGLE;
   assign ahb.HPROT     = HPROT_VAL;
   assign ahb.HMASTLOCK = 1'b0;
   assign ahb.HWDATA    = hwdata_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ahb.HTRANS = HT_IDLE;
      ahb.HWRITE = 1'b0;
      ahb.HADDR  = 32'h0;
      ahb.HSIZE  = SZ_BYTE;
      busy       = 1'b1;
      error      = 1'b0;
      rdata      = rdata_q;
      capture    = 1'b0;
      rdata_load = 1'b0;
      rdata_clr  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (local_err) begin
                  state_nxt = S_LOCALERR;
               end else begin
                  ahb.HTRANS = HT_NONSEQ;
                  ahb.HWRITE = wen;
                  ahb.HADDR  = {addr[31:2], dec_lo};
                  ahb.HSIZE  = dec_size;
                  if (ahb.HREADY) begin
                     capture   = 1'b1;
                     state_nxt = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (resp_err) begin
               // A slave that jumps straight to HREADY=1 with ERROR still ends the transfer.
               if (ahb.HREADY) begin
                  busy      = 1'b0;
                  error     = 1'b1;
                  rdata     = 32'h0;
                  rdata_clr = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_ERR2;
               end
            end else if (ahb.HREADY) begin
               busy       = 1'b0;
               rdata      = ahb.HRDATA;
               rdata_load = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         S_ERR2: begin
            if (ahb.HREADY) begin
               busy      = 1'b0;
               error     = 1'b1;
               rdata     = 32'h0;
               rdata_clr = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_LOCALERR: begin
            busy      = 1'b0;
            error     = 1'b1;
            rdata     = 32'h0;
            rdata_clr = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hwdata_q <= 32'h0;
         rdata_q  <= 32'h0;
      end else begin
         if (capture) hwdata_q <= wdata;
         if (rdata_load)     rdata_q <= ahb.HRDATA;
         else if (rdata_clr) rdata_q <= 32'h0;
      end
   end

endmodule
